core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control FSM that sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the instruction-memory handshake, pulses the decoder's `en` for exactly one cycle per instruction, and steers the data-memory handshake from the decoder's `memop`. It also issues register, CSR and PC write strobes, detects illegal opcodes and bus timeouts, and counts retired instructions.

## Interface
- `TIMEOUT_CYCLES`, default 16: max wait cycles for a memory ack; 0 disables the timeout.
- `clk` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `halt` in 1: hold the core in IDLE at an instruction boundary.
- `imem_req` out 1: instruction fetch request.
- `imem_ack` in 1: instruction word valid this cycle.
- `dec_en` out 1: decoder enable; one-cycle pulse.
- `opcode` in 7: decoder opcode.
- `memop` in 5: decoder memop.
- `rwEn` in 1: decoder register-write flag.
- `rd` in 5: decoder destination register.
- `csrEn` in 1: decoder CSR flag.
- `exec_en` out 1: ALU/branch unit enable; one-cycle pulse.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: data memory write (store).
- `dmem_width` out 3: `memop[2:0]`, valid while `dmem_req` is high.
- `dmem_ack` in 1: data access complete.
- `reg_we` out 1: register-file write pulse.
- `csr_we` out 1: CSR unit commit pulse.
- `pc_we` out 1: PC update pulse.
- `trap` out 1: trap pulse; the PC unit loads the trap vector.
- `trap_cause` out 2: 01 illegal, 10 imem timeout, 11 dmem timeout.
- `instret` out 32: retired-instruction count.
- `busy` out 1: high in any state except IDLE.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **IDLE**
  - `halt`=0 goes to FETCH; otherwise stay.
  - Reset state.
- **FETCH**
  - `imem_req`=1.
  - `imem_ack`=1 goes to DECODE.
  - Wait counter reaching `TIMEOUT_CYCLES-1` without ack goes to TRAP with cause 10.
- **DECODE**
  - `dec_en`=1 for this cycle only.
  - Always goes to EXEC.
  - Decoder outputs are valid from EXEC onward.
- **EXEC**
  - `exec_en`=1.
  - Opcode legality:
    - `opcode[1:0]` must be 11.
    - `opcode[6:2]` must be one of 00000, 00011, 00100, 00101, 01000, 01100, 01101, 11000, 11001, 11011, 11100.
  - Illegal opcode goes to TRAP with cause 01.
  - `memop[4:3]`=01 or 10 goes to MEM.
  - `memop[4:3]`=00 or 11 (fence) goes to WB.
- **MEM**
  - `dmem_req`=1.
  - `dmem_we` = (`memop[4:3]`==10).
  - `dmem_width`=`memop[2:0]`.
  - `dmem_ack` goes to WB.
  - Timeout goes to TRAP with cause 11.
- **WB**
  - `reg_we` = `rwEn` && `rd`!=0.
  - `csr_we` = `csrEn`.
  - `pc_we`=1.
  - `instret` increments by 1 (wraps at 2^32).
  - Next state: FETCH if `halt`=0, else IDLE.
- **TRAP**
  - `trap`=1 and `pc_we`=1.
  - `trap_cause` is latched on entry and held until the next trap.
  - `instret` is not incremented.
  - Next state: FETCH if `halt`=0, else IDLE.
- **Wait counter**
  - Cleared on entry to FETCH or MEM; increments each cycle without ack.
  - `TIMEOUT_CYCLES`=0 means the core waits forever.
  - Ack in the same cycle the counter reaches its limit: ack wins.
- All strobes are Moore outputs decoded from the state register, except:
  - `dmem_we`/`dmem_width` are gated by MEM.
  - `reg_we`/`csr_we` are gated by WB.

## Timing
- **Reset** (asserted at any time, including mid-MEM or mid-FETCH):
  - State goes to IDLE.
  - All outputs go to 0 asynchronously: strobes, `trap_cause`=00, `instret`=0, `busy`=0.
  - No partial writeback occurs.
- **First request:** `imem_req` rises in the 2nd cycle after reset deasserts, assuming `halt`=0.
- **Minimum latency**, with ack in the first request cycle:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
- `imem_req`/`dmem_req` stay asserted through the ack cycle and deassert the cycle after.
- `halt` is sampled only in IDLE, WB and TRAP. It never aborts an instruction in flight.
- Back-to-back instructions: WB is followed directly by FETCH, with no idle bubble.

## Test plan
- **Basic sequence:** reset, `halt`=0, imem ack immediate, `opcode`=0110011, `rwEn`=1, `rd`=5, `memop`=0 → states FETCH, DECODE, EXEC, WB in 4 cycles; `reg_we`=1 in WB; `instret`=1.
- **Load with slow memory:** `memop`=01010, `dmem_ack` after 3 cycles → `dmem_we`=0, `dmem_width`=010, `dmem_req` high for 4 cycles; WB follows; `reg_we`=1.
- **Store, then rd=0 write:**
  - Store with `memop`=10010 → `dmem_we`=1 and `reg_we`=0.
  - Then `rwEn`=1 with `rd`=0 → `reg_we`=0 and `pc_we`=1.
- **Illegal opcode:** `opcode`=0000111 → TRAP after EXEC; `trap`=1; `trap_cause`=01; `instret` unchanged; next state FETCH.
- **Timeout:** `TIMEOUT_CYCLES`=4, no `imem_ack` → TRAP entered after 4 FETCH cycles with cause 10. Repeat with ack on the 4th cycle → DECODE, no trap.
- **Halt and async reset:**
  - `halt`=1 during MEM → instruction completes, then IDLE with `busy`=0.
  - Reset asserted mid-MEM → `dmem_req`=0 and `instret`=0 immediately, before the next edge.

Source files
------------

// File: rtl/core_sequencer_if.sv
// -----------------------------------------------------------------------------
// core_sequencer_if
// Purpose : bundles every handshake and strobe between the instruction
//           sequencer and the blocks it controls (instruction memory, decoder,
//           ALU/branch unit, data memory, register file, CSR unit, PC unit).
// Modports:
//   master - the sequencer: drives requests, enables, write strobes,
//            trap/trap_cause, instret and busy; observes halt, acks and the
//            decoder fields.
//   slave  - the surrounding datapath/memories: the mirror image.
// Signals :
//   halt        core hold request, honoured at instruction boundaries
//   imem_req/ack       instruction fetch handshake
//   dec_en             decoder enable pulse
//   opcode/memop/rwEn/rd/csrEn  decoder outputs
//   exec_en            ALU/branch enable pulse
//   dmem_req/we/width/ack       data memory handshake
//   reg_we/csr_we/pc_we         commit strobes
//   trap/trap_cause            trap pulse and latched cause
//   instret            retired-instruction count
//   busy               high whenever the core is not idle
// -----------------------------------------------------------------------------
interface core_sequencer_if;
   logic        halt;
   logic        imem_req;
   logic        imem_ack;
   logic        dec_en;
   logic [6:0]  opcode;
   logic [4:0]  memop;
   logic        rwEn;
   logic [4:0]  rd;
   logic        csrEn;
   logic        exec_en;
   logic        dmem_req;
   logic        dmem_we;
   logic [2:0]  dmem_width;
   logic        dmem_ack;
   logic        reg_we;
   logic        csr_we;
   logic        pc_we;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [31:0] instret;
   logic        busy;

   modport master (
      input  halt, imem_ack, opcode, memop, rwEn, rd, csrEn, dmem_ack,
      output imem_req, dec_en, exec_en, dmem_req, dmem_we, dmem_width,
             reg_we, csr_we, pc_we, trap, trap_cause, instret, busy
   );

   modport slave (
      output halt, imem_ack, opcode, memop, rwEn, rd, csrEn, dmem_ack,
      input  imem_req, dec_en, exec_en, dmem_req, dmem_we, dmem_width,
             reg_we, csr_we, pc_we, trap, trap_cause, instret, busy
   );
endinterface

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
// Purpose : multi-cycle control FSM stepping one instruction at a time through
//           FETCH -> DECODE -> EXEC -> (MEM) -> WB, with a TRAP path for
//           illegal opcodes and memory timeouts. Counts retired instructions.
// Parameters:
//   TIMEOUT_CYCLES - max cycles to wait for a memory ack (0 = wait forever)
// Ports:
//   clk    - core clock, rising edge
//   reset  - asynchronous active-high reset, returns to IDLE with all outputs 0
//   io_bus - core_sequencer_if.master (handshakes, decoder fields, strobes)
// -----------------------------------------------------------------------------
module core_sequencer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   core_sequencer_if.master io_bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_TRAP   = 3'd6;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
   localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

   // Counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int            CW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] WAIT_LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   logic [2:0]    r_state;
   logic [2:0]    w_state_next;
   logic [CW-1:0] r_wait_cnt;
   logic [1:0]    r_trap_cause;
   logic [1:0]    w_trap_cause_next;
   logic [31:0]   r_instret;
   logic          w_timeout;
   logic          w_waiting;
   logic          w_mem_access;
   logic          w_legal;

   function automatic logic f_legal(input logic [6:0] op);
      logic ok;
      ok = 1'b0;
      if (op[1:0] == 2'b11) begin
         case (op[6:2])
            5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
            5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: ok = 1'b1;
            default:                                           ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   assign w_legal      = f_legal(io_bus.opcode);
   // Loads (01) and stores (10) touch data memory; 00 and fence (11) do not.
   assign w_mem_access = (io_bus.memop[4:3] == 2'b01) || (io_bus.memop[4:3] == 2'b10);
   // Ack in the limit cycle is handled first in the next-state logic, so ack wins.
   assign w_timeout    = TIMEOUT_EN && (r_wait_cnt == WAIT_LIMIT);
   assign w_waiting    = ((r_state == S_FETCH) && !io_bus.imem_ack) ||
                         ((r_state == S_MEM)   && !io_bus.dmem_ack);

   always_comb begin
      w_state_next      = r_state;
      w_trap_cause_next = r_trap_cause;
      case (r_state)
         S_IDLE:   if (!io_bus.halt) w_state_next = S_FETCH;
         S_FETCH: begin
            if (io_bus.imem_ack) begin
               w_state_next = S_DECODE;
            end else if (w_timeout) begin
               w_state_next      = S_TRAP;
               w_trap_cause_next = CAUSE_IMEM_TO;
            end
         end
         S_DECODE: w_state_next = S_EXEC;
         S_EXEC: begin
            if (!w_legal) begin
               w_state_next      = S_TRAP;
               w_trap_cause_next = CAUSE_ILLEGAL;
            end else if (w_mem_access) begin
               w_state_next = S_MEM;
            end else begin
               w_state_next = S_WB;
            end
         end
         S_MEM: begin
            if (io_bus.dmem_ack) begin
               w_state_next = S_WB;
            end else if (w_timeout) begin
               w_state_next      = S_TRAP;
               w_trap_cause_next = CAUSE_DMEM_TO;
            end
         end
         S_WB, S_TRAP: w_state_next = io_bus.halt ? S_IDLE : S_FETCH;
         default:      w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_wait_cnt   <= '0;
         r_trap_cause <= 2'b00;
         r_instret    <= 32'd0;
      end else begin
         r_state      <= w_state_next;
         r_trap_cause <= w_trap_cause_next;
         // FETCH and MEM are never adjacent, so clearing in every other
         // state (and on ack) is equivalent to clearing on entry. Saturates
         // at the limit, which also keeps it parked when timeouts are off.
         if (w_waiting) begin
            if (r_wait_cnt != WAIT_LIMIT) r_wait_cnt <= r_wait_cnt + 1'b1;
         end else begin
            r_wait_cnt <= '0;
         end
         if (r_state == S_WB) r_instret <= r_instret + 32'd1;
      end
   end

   assign io_bus.imem_req   = (r_state == S_FETCH);
   assign io_bus.dec_en     = (r_state == S_DECODE);
   assign io_bus.exec_en    = (r_state == S_EXEC);
   assign io_bus.dmem_req   = (r_state == S_MEM);
   assign io_bus.dmem_we    = (r_state == S_MEM) && (io_bus.memop[4:3] == 2'b10);
   assign io_bus.dmem_width = (r_state == S_MEM) ? io_bus.memop[2:0] : 3'b000;
   assign io_bus.reg_we     = (r_state == S_WB) && io_bus.rwEn && (io_bus.rd != 5'd0);
   assign io_bus.csr_we     = (r_state == S_WB) && io_bus.csrEn;
   assign io_bus.pc_we      = (r_state == S_WB) || (r_state == S_TRAP);
   assign io_bus.trap       = (r_state == S_TRAP);
   assign io_bus.trap_cause = r_trap_cause;
   assign io_bus.instret    = r_instret;
   assign io_bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
// Drives directed and random instructions through core_sequencer
// (TIMEOUT_CYCLES=4). For each instruction the expected cycle-by-cycle phase
// list is built from the sequencing rules, then walked while the acks are
// driven and every output is compared.
// -----------------------------------------------------------------------------
module tb_core_sequencer;
   localparam int T = 4;

   localparam int P_IDLE   = 0;
   localparam int P_FETCH  = 1;
   localparam int P_DECODE = 2;
   localparam int P_EXEC   = 3;
   localparam int P_MEM    = 4;
   localparam int P_WB     = 5;
   localparam int P_TRAP   = 6;

   logic clk;
   logic reset;

   core_sequencer_if bus_if();

   core_sequencer #(.TIMEOUT_CYCLES(T)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_instret = 32'd0;
   logic [1:0]  exp_cause   = 2'b00;
   int          ph_q[$];
   int          k_q[$];
   int          legal_tbl[11] = '{0, 3, 4, 5, 8, 12, 13, 24, 25, 27, 28};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic is_legal(input logic [6:0] op);
      if (op[1:0] != 2'b11) return 1'b0;
      foreach (legal_tbl[i]) if (int'(op[6:2]) == legal_tbl[i]) return 1'b1;
      return 1'b0;
   endfunction

   // {imem_req, dec_en, exec_en, dmem_req, dmem_we, dmem_width[2:0],
   //  reg_we, csr_we, pc_we, trap, busy}
   function automatic logic [12:0] exp_vec(input int p, input logic [4:0] mo,
                                           input logic rw, input logic [4:0] rdv,
                                           input logic csr);
      logic [12:0] v;
      v = '0;
      case (p)
         P_FETCH:  v[12] = 1'b1;
         P_DECODE: v[11] = 1'b1;
         P_EXEC:   v[10] = 1'b1;
         P_MEM: begin
            v[9]   = 1'b1;
            v[8]   = (mo[4:3] == 2'b10);
            v[7:5] = mo[2:0];
         end
         P_WB: begin
            v[4] = rw && (rdv != 5'd0);
            v[3] = csr;
            v[2] = 1'b1;
         end
         P_TRAP: begin
            v[2] = 1'b1;
            v[1] = 1'b1;
         end
         default: ;
      endcase
      v[0] = (p != P_IDLE);
      return v;
   endfunction

   function automatic logic [12:0] obs_vec();
      return {bus_if.imem_req, bus_if.dec_en, bus_if.exec_en, bus_if.dmem_req,
              bus_if.dmem_we, bus_if.dmem_width, bus_if.reg_we, bus_if.csr_we,
              bus_if.pc_we, bus_if.trap, bus_if.busy};
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_vec"}, 32'(obs_vec()), 32'd0);
      check({tag, "_cause"}, 32'(bus_if.trap_cause), 32'd0);
      check({tag, "_instret"}, bus_if.instret, 32'd0);
   endtask

   // Called at posedge+1 or later; leaves the bench at posedge+1 of the
   // first FETCH cycle.
   task automatic do_reset();
      reset = 1'b1;
      bus_if.halt = 1'b0;
      bus_if.imem_ack = 1'b0;
      bus_if.dmem_ack = 1'b0;
      exp_instret = 32'd0;
      exp_cause = 2'b00;
      @(posedge clk); #1;
      check_all_zero("in_reset");
      reset = 1'b0;
      #1;
      check("post_reset_idle", 32'(obs_vec()), 32'(exp_vec(P_IDLE, 5'd0, 1'b0, 5'd0, 1'b0)));
      @(posedge clk); #1;
   endtask

   // Runs one instruction starting in its first FETCH cycle. ia/da: cycle
   // index (0-based) at which imem/dmem ack is given (>= T means never).
   // hlt: halt held for the whole instruction, released after some idle
   // cycles. rst_at: phase index where reset is asserted asynchronously.
   task automatic run_instr(input string tag, input int ia, input logic [6:0] op,
                            input logic [4:0] mo, input logic rw, input logic [4:0] rdv,
                            input logic csr, input int da, input logic hlt,
                            input int rst_at);
      logic [1:0] cause;
      int p;
      int k;
      cause = 2'b00;
      ph_q.delete();
      k_q.delete();
      for (int i = 0; i < ((ia < T) ? ia + 1 : T); i++) begin
         ph_q.push_back(P_FETCH); k_q.push_back(i);
      end
      if (ia >= T) begin
         ph_q.push_back(P_TRAP); k_q.push_back(0); cause = 2'b10;
      end else begin
         ph_q.push_back(P_DECODE); k_q.push_back(0);
         ph_q.push_back(P_EXEC);   k_q.push_back(0);
         if (!is_legal(op)) begin
            ph_q.push_back(P_TRAP); k_q.push_back(0); cause = 2'b01;
         end else if (mo[4:3] == 2'b01 || mo[4:3] == 2'b10) begin
            for (int i = 0; i < ((da < T) ? da + 1 : T); i++) begin
               ph_q.push_back(P_MEM); k_q.push_back(i);
            end
            if (da >= T) begin
               ph_q.push_back(P_TRAP); k_q.push_back(0); cause = 2'b11;
            end else begin
               ph_q.push_back(P_WB); k_q.push_back(0);
            end
         end else begin
            ph_q.push_back(P_WB); k_q.push_back(0);
         end
      end
      if (hlt) for (int i = 0; i < 3; i++) begin
         ph_q.push_back(P_IDLE); k_q.push_back(0);
      end

      $display("instr %s op=%b memop=%b rwEn=%b rd=%0d csrEn=%b ia=%0d da=%0d halt=%b cycles=%0d",
               tag, op, mo, rw, rdv, csr, ia, da, hlt, ph_q.size());

      bus_if.halt   = hlt;
      bus_if.opcode = op;
      bus_if.memop  = mo;
      bus_if.rwEn   = rw;
      bus_if.rd     = rdv;
      bus_if.csrEn  = csr;
      for (int i = 0; i < ph_q.size(); i++) begin
         p = ph_q[i];
         k = k_q[i];
         bus_if.imem_ack = (p == P_FETCH) && (k == ia);
         bus_if.dmem_ack = (p == P_MEM) && (k == da);
         if (hlt && p == P_IDLE && i == ph_q.size() - 1) bus_if.halt = 1'b0;
         if (p == P_TRAP) exp_cause = cause;
         #1;
         check($sformatf("%s_ph%0d_vec", tag, i), 32'(obs_vec()), 32'(exp_vec(p, mo, rw, rdv, csr)));
         check($sformatf("%s_ph%0d_cause", tag, i), 32'(bus_if.trap_cause), 32'(exp_cause));
         check($sformatf("%s_ph%0d_instret", tag, i), bus_if.instret, exp_instret);
         if (i == rst_at) begin
            reset = 1'b1;
            #1;
            check_all_zero({tag, "_async_rst"});
            bus_if.imem_ack = 1'b0;
            bus_if.dmem_ack = 1'b0;
            return;
         end
         if (p == P_WB) exp_instret = exp_instret + 32'd1;
         @(posedge clk); #1;
      end
      bus_if.imem_ack = 1'b0;
      bus_if.dmem_ack = 1'b0;
   endtask

   initial begin
      logic [6:0] r_op;
      reset = 1'b0;
      bus_if.halt = 1'b0;
      bus_if.imem_ack = 1'b0;
      bus_if.dmem_ack = 1'b0;
      bus_if.opcode = 7'd0;
      bus_if.memop = 5'd0;
      bus_if.rwEn = 1'b0;
      bus_if.rd = 5'd0;
      bus_if.csrEn = 1'b0;
      #1 reset = 1'b1;
      #1 check_all_zero("initial_reset");
      do_reset();

      // name, ia, opcode, memop, rwEn, rd, csrEn, da, halt, rst_at
      run_instr("basic_alu",   0, 7'b0110011, 5'b00000, 1'b1, 5'd5, 1'b0, 0, 1'b0, -1);
      run_instr("load_slow",   0, 7'b0000011, 5'b01010, 1'b1, 5'd7, 1'b0, 3, 1'b0, -1);
      run_instr("store",       1, 7'b0100011, 5'b10010, 1'b0, 5'd3, 1'b0, 0, 1'b0, -1);
      run_instr("rd_zero",     0, 7'b0010011, 5'b00000, 1'b1, 5'd0, 1'b0, 0, 1'b0, -1);
      run_instr("illegal",     0, 7'b0000111, 5'b00000, 1'b1, 5'd4, 1'b0, 0, 1'b0, -1);
      run_instr("imem_to",    99, 7'b0110011, 5'b00000, 1'b1, 5'd1, 1'b0, 0, 1'b0, -1);
      run_instr("imem_ack4",   3, 7'b0110011, 5'b00000, 1'b1, 5'd1, 1'b0, 0, 1'b0, -1);
      run_instr("dmem_to",     0, 7'b0000011, 5'b01001, 1'b1, 5'd2, 1'b0, 99, 1'b0, -1);
      run_instr("dmem_ack4",   0, 7'b0100011, 5'b10001, 1'b0, 5'd2, 1'b0, 3, 1'b0, -1);
      run_instr("fence_csr",   0, 7'b1110011, 5'b11000, 1'b1, 5'd9, 1'b1, 0, 1'b0, -1);
      run_instr("halt_mem",    0, 7'b0000011, 5'b01000, 1'b1, 5'd6, 1'b0, 2, 1'b1, -1);
      run_instr("halt_trap",  99, 7'b0110011, 5'b00000, 1'b0, 5'd0, 1'b0, 0, 1'b1, -1);
      run_instr("rst_in_mem",  0, 7'b0000011, 5'b01010, 1'b1, 5'd8, 1'b0, 99, 1'b0, 4);
      do_reset();
      run_instr("after_rst",   0, 7'b0110011, 5'b00000, 1'b1, 5'd5, 1'b0, 0, 1'b0, -1);
      run_instr("rst_in_fetch", 3, 7'b0110011, 5'b00000, 1'b1, 5'd5, 1'b0, 0, 1'b0, 1);
      do_reset();

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 4) != 0)
            r_op = {5'(legal_tbl[$urandom_range(0, 10)]), 2'b11};
         else
            r_op = 7'($urandom);
         run_instr($sformatf("rand%0d", n), int'($urandom_range(0, 5)), r_op,
                   5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
                   int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
